// File: rtl/jk_mod_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : jk_mod_counter                                           |
// | Description : Synchronous modulo-N up/down counter built from per-bit  |
// |               JK cells. Drives the J/K excitation out so an external   |
// |               master-slave JK bank on the same edge tracks q exactly.  |
// | Option      : JK_MOD_COUNTER_SAT_EN - saturate at the ends instead of  |
// |               wrapping (load behaviour unchanged).                     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             load_err
);

  // MODULUS may equal 2**WIDTH, so it is only representable at WIDTH+1 bits.
  localparam logic [WIDTH:0]   c_mod_ext = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] c_max     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_zero    = '0;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_bar;
  logic             r_load_err;

  logic             w_load_ok;
  logic [WIDTH:0]   w_inc_ext;
  logic [WIDTH:0]   w_dec_ext;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_up_wrap;
  logic [WIDTH-1:0] w_dn_wrap;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_jk_next;

  assign w_load_ok = ({1'b0, load_val} < c_mod_ext);

  // Step arithmetic is one bit wider than the state. The extended results
  // double as end detectors: q+1 reaching MODULUS marks the top, and a borrow
  // out of q-1 marks zero.
  assign w_inc_ext = {1'b0, r_q} + (WIDTH+1)'(1);
  assign w_dec_ext = {1'b0, r_q} - (WIDTH+1)'(1);
  assign w_at_max  = (w_inc_ext == c_mod_ext);
  assign w_at_zero = w_dec_ext[WIDTH];

`ifdef JK_MOD_COUNTER_SAT_EN
  // Saturating build: at either end the count simply holds.
  assign w_up_wrap = r_q;
  assign w_dn_wrap = r_q;
`else
  assign w_up_wrap = c_zero;
  assign w_dn_wrap = c_max;
`endif

  // Next-count selection: load beats count; a rejected load holds the count.
  always_comb begin
    w_next = r_q;
    if (load) begin
      if (w_load_ok) begin
        w_next = load_val;
      end
    end else if (en) begin
      if (up_dn) begin
        w_next = w_at_max ? w_up_wrap : w_inc_ext[WIDTH-1:0];
      end else begin
        w_next = w_at_zero ? w_dn_wrap : w_dec_ext[WIDTH-1:0];
      end
    end
  end

  // Excitation with don't-cares forced to 0, so J and K are never both high.
  assign w_j = ~r_q & w_next;
  assign w_k = r_q & ~w_next;

  // One JK cell per bit: the register is loaded from the JK characteristic
  // equation, not from w_next directly, so it mirrors the external bank.
  for (genvar i = 0; i < WIDTH; i++) begin : g_jk_cell
    assign w_jk_next[i] = (w_j[i] & ~r_q[i]) | (~w_k[i] & r_q[i]);
  end

  // State, its registered complement and the rejected-load flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_q        <= '0;
      r_q_bar    <= '1;
      r_load_err <= 1'b0;
    end else begin
      r_q        <= w_jk_next;
      r_q_bar    <= ~w_jk_next;
      r_load_err <= load & ~w_load_ok;
    end
  end

  assign q        = r_q;
  assign q_bar    = r_q_bar;
  assign j_vec    = w_j;
  assign k_vec    = w_k;
  assign load_err = r_load_err;
  assign tc       = en & ~load & ((up_dn & w_at_max) | (~up_dn & w_at_zero));

endmodule
`default_nettype wire

// File: tb/tb_jk_mod_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_jk_mod_counter                                        |
// | Description : Self-checking bench for jk_mod_counter (WIDTH=4, MOD=10) |
// |               with directed scenarios, randomized traffic and an       |
// |               arithmetic reference model. Honours JK_MOD_COUNTER_SAT_EN.|
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_jk_mod_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         clr;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic [W-1:0] j_vec;
  logic [W-1:0] k_vec;
  logic         tc;
  logic         load_err;

  int checks   = 0;
  int failures = 0;

  int model_q   = 0;
  bit model_err = 1'b0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk      (clk),
    .clr      (clr),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .q_bar    (q_bar),
    .j_vec    (j_vec),
    .k_vec    (k_vec),
    .tc       (tc),
    .load_err (load_err)
  );

  // Reference next count from the counting rules, in plain integer arithmetic.
  function automatic int ref_next(int cur, bit e, bit u, bit ld, int lv);
    if (ld) return (lv < M) ? lv : cur;
    if (!e) return cur;
`ifdef JK_MOD_COUNTER_SAT_EN
    if (u) return (cur + 1 > M - 1) ? M - 1 : cur + 1;
    return (cur == 0) ? 0 : cur - 1;
`else
    if (u) return (cur + 1) % M;
    return (cur + M - 1) % M;
`endif
  endfunction

  // Expected count for the up-count scenario after n edges from zero.
  function automatic int up_seq(int n);
`ifdef JK_MOD_COUNTER_SAT_EN
    return (n > M - 1) ? M - 1 : n;
`else
    return n % M;
`endif
  endfunction

  // Reference model state, advanced on the same edges as the DUT.
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      model_q   = 0;
      model_err = 1'b0;
    end else begin
      model_err = load && (int'(load_val) >= M);
      model_q   = ref_next(model_q, en, up_dn, load, int'(load_val));
    end
  end

  // Every cycle, mid low phase: state, complement, flag, excitation, tc.
  always @(negedge clk) begin
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_nx;
    logic [W-1:0] applied;
    logic         exp_tc;
    #2;
    exp_q   = W'(model_q);
    exp_nx  = W'(ref_next(model_q, en, up_dn, load, int'(load_val)));
    applied = (j_vec & ~q) | (~k_vec & q);
    exp_tc  = en && !load && ((up_dn && model_q == M - 1) || (!up_dn && model_q == 0));
    checks++;
    if (q !== exp_q) begin
      failures++; $display("FAIL mon_q t=%0t got=%h want=%h", $time, q, exp_q);
    end
    checks++;
    if (q_bar !== ~exp_q) begin
      failures++; $display("FAIL mon_q_bar t=%0t got=%h want=%h", $time, q_bar, ~exp_q);
    end
    checks++;
    if (load_err !== model_err) begin
      failures++; $display("FAIL mon_load_err t=%0t got=%b want=%b", $time, load_err, model_err);
    end
    checks++;
    if (applied !== exp_nx) begin
      failures++; $display("FAIL mon_jk_next t=%0t got=%h want=%h", $time, applied, exp_nx);
    end
    checks++;
    if ((j_vec & k_vec) !== '0) begin
      failures++; $display("FAIL mon_j_and_k t=%0t got=%h want=0", $time, j_vec & k_vec);
    end
    checks++;
    if (tc !== exp_tc) begin
      failures++; $display("FAIL mon_tc t=%0t got=%b want=%b", $time, tc, exp_tc);
    end
  end

  task automatic drive(bit e, bit u, bit ld, logic [W-1:0] lv);
    @(negedge clk);
    en = e; up_dn = u; load = ld; load_val = lv;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q !== 4'h0) begin failures++; $display("FAIL reset_q got=%h want=0", q); end
      checks++;
      if (q_bar !== 4'hF) begin failures++; $display("FAIL reset_q_bar got=%h want=f", q_bar); end
    end
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'h1) begin failures++; $display("FAIL reset_release_q got=%h want=1", q); end
  endtask

  task automatic test_up_wrap();
    int prev;
    drive(1'b0, 1'b1, 1'b1, 4'd0);
    @(posedge clk); #1;
    checks++;
    if (q !== 4'h0) begin failures++; $display("FAIL up_start_q got=%h want=0", q); end
    for (int i = 1; i <= 12; i++) begin
      prev = up_seq(i - 1);
      drive(1'b1, 1'b1, 1'b0, 4'd0);
      #2;
      checks++;
      if (tc !== (prev == M - 1)) begin
        failures++; $display("FAIL up_tc step=%0d got=%b want=%b", i, tc, prev == M - 1);
      end
      if (prev == M - 1) begin
        checks++;
        if (j_vec !== 4'b0000) begin failures++; $display("FAIL up_j_at9 got=%b want=0000", j_vec); end
        checks++;
`ifdef JK_MOD_COUNTER_SAT_EN
        if (k_vec !== 4'b0000) begin failures++; $display("FAIL up_k_at9 got=%b want=0000", k_vec); end
`else
        if (k_vec !== 4'b1001) begin failures++; $display("FAIL up_k_at9 got=%b want=1001", k_vec); end
`endif
      end
      @(posedge clk); #1;
      checks++;
      if (q !== W'(up_seq(i))) begin
        failures++; $display("FAIL up_q step=%0d got=%h want=%h", i, q, W'(up_seq(i)));
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [W-1:0] exp;
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    @(posedge clk); #1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      #2;
      if (i == 1) begin
        checks++;
        if (tc !== 1'b1) begin failures++; $display("FAIL dn_tc_at0 got=%b want=1", tc); end
        checks++;
`ifdef JK_MOD_COUNTER_SAT_EN
        if (j_vec !== 4'b0000) begin failures++; $display("FAIL dn_j_at0 got=%b want=0000", j_vec); end
`else
        if (j_vec !== 4'b1001) begin failures++; $display("FAIL dn_j_at0 got=%b want=1001", j_vec); end
`endif
      end
      @(posedge clk); #1;
`ifdef JK_MOD_COUNTER_SAT_EN
      exp = 4'd0;
`else
      exp = W'(M - i);
`endif
      checks++;
      if (q !== exp) begin failures++; $display("FAIL dn_q step=%0d got=%h want=%h", i, q, exp); end
    end
  endtask

  task automatic test_load();
    drive(1'b1, 1'b1, 1'b1, 4'd7);
    #2;
    checks++;
    if (tc !== 1'b0) begin failures++; $display("FAIL load_tc got=%b want=0", tc); end
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd7) begin failures++; $display("FAIL load_ok_q got=%h want=7", q); end
    drive(1'b1, 1'b1, 1'b1, 4'd12);
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd7) begin failures++; $display("FAIL load_bad_q got=%h want=7", q); end
    checks++;
    if (load_err !== 1'b1) begin failures++; $display("FAIL load_err_set got=%b want=1", load_err); end
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk); #1;
    checks++;
    if (load_err !== 1'b0) begin failures++; $display("FAIL load_err_clear got=%b want=0", load_err); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] bad [3] = '{4'd12, 4'd15, 4'd10};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, bad[i]);
      @(posedge clk); #1;
      checks++;
      if (load_err !== 1'b1) begin failures++; $display("FAIL b2b_err idx=%0d got=%b want=1", i, load_err); end
      checks++;
      if (q !== 4'd7) begin failures++; $display("FAIL b2b_q idx=%0d got=%h want=7", i, q); end
    end
    drive(1'b0, 1'b0, 1'b1, 4'd3);
    @(posedge clk); #1;
    checks++;
    if (load_err !== 1'b0 || q !== 4'd3) begin
      failures++; $display("FAIL b2b_end got=%b/%h want=0/3", load_err, q);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b1, 4'd5);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 4'd12);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    #3; clr = 1'b0; #1;
    checks++;
    if (q !== 4'd0) begin failures++; $display("FAIL async_q got=%h want=0", q); end
    checks++;
    if (q_bar !== 4'hF) begin failures++; $display("FAIL async_q_bar got=%h want=f", q_bar); end
    checks++;
    if (load_err !== 1'b0) begin failures++; $display("FAIL async_err got=%b want=0", load_err); end
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd1) begin failures++; $display("FAIL async_restart got=%h want=1", q); end
  endtask

  task automatic test_random();
    bit release_pending = 1'b0;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0, W'($urandom_range(0, 15)));
      if (release_pending) begin clr = 1'b1; release_pending = 1'b0; end
      if ($urandom_range(0, 49) == 0) begin
        #3; clr = 1'b0; #1;
        checks++;
        if (q !== 4'd0) begin failures++; $display("FAIL rnd_async_q n=%0d got=%h want=0", n, q); end
        release_pending = 1'b1;
      end
      @(posedge clk); #1;
      checks++;
      if (q !== W'(model_q)) begin
        failures++; $display("FAIL rnd_q n=%0d got=%h want=%h", n, q, W'(model_q));
      end
    end
    @(negedge clk); clr = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = '0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_back_to_back();
    test_async_reset();
    test_random();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
